// File: rtl/sensor_frame_gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_frame_gate_pkg
//  Description : Shared types and constants for the sensor frame gate and
//                for histogram_module sizing (default frame geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
package sensor_frame_gate_pkg;

    // One sensor beat carries two 10-bit pixels.
    localparam int c_pix_w = 10;
    localparam int c_bus_w = 2 * c_pix_w;

    // Default frame geometry, also used by histogram_module instances.
    localparam int c_line_words_def  = 640;
    localparam int c_frame_lines_def = 400;
    localparam int c_cnt_w_def       = 16;

    // Frame gate state encoding.
    localparam int         c_state_w  = 2;
    localparam logic [1:0] c_st_sync  = 2'd0;
    localparam logic [1:0] c_st_armed = 2'd1;
    localparam logic [1:0] c_st_pass  = 2'd2;
    localparam logic [1:0] c_st_drop  = 2'd3;

    // Two-pixel bus word as presented by the sensor: {pixel_b, pixel_a}.
    typedef struct packed {
        logic [c_pix_w-1:0] pixel_b;
        logic [c_pix_w-1:0] pixel_a;
    } pixel_pair_t;

endpackage
`default_nettype wire

// File: rtl/sensor_frame_gate_if.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_frame_gate_if
//  Description : Parallel video bus (two-pixel data, frame strobe, line
//                strobe). The master drives the bus, the slave receives it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sensor_frame_gate_if;
    import sensor_frame_gate_pkg::*;

    pixel_pair_t pixel_data;
    logic        frame_valid;
    logic        line_valid;

    modport master (
        output pixel_data,
        output frame_valid,
        output line_valid
    );

    modport slave (
        input  pixel_data,
        input  frame_valid,
        input  line_valid
    );

endinterface
`default_nettype wire

// File: rtl/sensor_frame_gate_frame_geom_checker.sv
`default_nettype none
// ============================================================================
//  Module      : frame_geom_checker
//  Description : Counts words per line and lines per frame on the gated
//                video stream, latches the most recent counts and raises
//                sticky flags when they differ from the expected geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_geom_checker
    import sensor_frame_gate_pkg::*;
#(
    parameter int LINE_WORDS  = c_line_words_def,
    parameter int FRAME_LINES = c_frame_lines_def,
    parameter int CNT_W       = c_cnt_w_def
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              start,
    input  wire              frame_valid,
    input  wire              line_valid,
    input  wire              err_clear,
    output logic [CNT_W-1:0] last_line_words,
    output logic [CNT_W-1:0] last_frame_lines,
    output logic             err_line_len,
    output logic             err_frame_lines
);

    localparam logic [CNT_W-1:0] c_line_words  = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] c_frame_lines = CNT_W'(FRAME_LINES);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    logic             r_fv_d;
    logic             r_lv_d;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] r_last_line_words;
    logic [CNT_W-1:0] r_last_frame_lines;
    logic             r_err_line_len;
    logic             r_err_frame_lines;

    logic             w_line_fall;
    logic             w_frame_fall;
    logic [CNT_W-1:0] w_line_cnt_next;
    logic             w_line_err;
    logic             w_frame_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + c_one;
    endfunction

    // The gated stream is the input, so falls are seen in the cycle after
    // the output edge and results land one clock later.
    assign w_line_fall  = r_lv_d & ~line_valid;
    assign w_frame_fall = r_fv_d & ~frame_valid;

    // A line still open when the frame ends is counted in the frame total.
    assign w_line_cnt_next = w_line_fall ? sat_inc(r_line_cnt) : r_line_cnt;
    assign w_line_err      = w_line_fall  & (r_word_cnt != c_line_words);
    assign w_frame_err     = w_frame_fall & (w_line_cnt_next != c_frame_lines);

    // Delayed copies of the gated strobes for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fv_d <= 1'b0;
            r_lv_d <= 1'b0;
        end else begin
            r_fv_d <= frame_valid;
            r_lv_d <= line_valid;
        end
    end

    // Word and line counters, cleared when a forwarded frame begins.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            r_word_cnt <= '0;
            r_line_cnt <= '0;
        end else begin
            if (w_line_fall) begin
                r_word_cnt <= '0;
            end else if (frame_valid && line_valid) begin
                r_word_cnt <= sat_inc(r_word_cnt);
            end
            r_line_cnt <= w_line_cnt_next;
        end
    end

    // Latch the geometry of the most recent line and frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_line_words  <= '0;
            r_last_frame_lines <= '0;
        end else begin
            if (w_line_fall) begin
                r_last_line_words <= r_word_cnt;
            end
            if (w_frame_fall) begin
                r_last_frame_lines <= w_line_cnt_next;
            end
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_line_len    <= 1'b0;
            r_err_frame_lines <= 1'b0;
        end else begin
            if (w_line_err) begin
                r_err_line_len <= 1'b1;
            end else if (err_clear) begin
                r_err_line_len <= 1'b0;
            end
            if (w_frame_err) begin
                r_err_frame_lines <= 1'b1;
            end else if (err_clear) begin
                r_err_frame_lines <= 1'b0;
            end
        end
    end

    assign last_line_words  = r_last_line_words;
    assign last_frame_lines = r_last_frame_lines;
    assign err_line_len     = r_err_line_len;
    assign err_frame_lines  = r_err_frame_lines;

endmodule
`default_nettype wire

// File: rtl/sensor_frame_gate.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_frame_gate
//  Description : Registers the raw sensor bus and forwards only whole frames
//                to histogram_module, with optional 1-in-(N+1) frame
//                decimation and per-frame geometry checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module sensor_frame_gate
    import sensor_frame_gate_pkg::*;
#(
    parameter int LINE_WORDS  = c_line_words_def,
    parameter int FRAME_LINES = c_frame_lines_def,
    parameter int CNT_W       = c_cnt_w_def
) (
    input  wire                       clk,
    input  wire                       reset,
    input  wire                       enable,
    input  wire [3:0]                 skip,
    input  wire                       err_clear,
    sensor_frame_gate_if.slave        raw,
    sensor_frame_gate_if.master       gated,
    output logic                      frame_done,
    output logic [CNT_W-1:0]          last_line_words,
    output logic [CNT_W-1:0]          last_frame_lines,
    output logic                      err_line_len,
    output logic                      err_frame_lines
);

    localparam logic [3:0] c_skip_zero = 4'd0;
    localparam logic [3:0] c_skip_one  = 4'd1;

    // Stage-1 copy of the raw bus and its delayed frame strobe.
    pixel_pair_t          r_data;
    logic                 r_fv;
    logic                 r_lv;
    logic                 r_fv_d;

    logic [c_state_w-1:0] r_state;
    logic [3:0]           r_skip_cnt;

    // Output register feeding histogram_module.
    pixel_pair_t          r_out_data;
    logic                 r_out_fv;
    logic                 r_out_lv;
    logic                 r_frame_done;

    logic                 w_fv_rise;
    logic                 w_fv_fall;
    logic                 w_start;
    logic                 w_fwd;

    assign w_fv_rise = r_fv & ~r_fv_d;
    assign w_fv_fall = ~r_fv & r_fv_d;

    // A frame is accepted on the very cycle its rising edge is seen, so the
    // first beat is forwarded with the same latency as the rest.
    assign w_start = (r_state == c_st_armed) & w_fv_rise & enable & (r_skip_cnt == c_skip_zero);
    assign w_fwd   = (r_state == c_st_pass) | w_start;

    // Stage-1 capture runs through reset so that SYNC sees the true bus
    // level as soon as reset is released.
    always_ff @(posedge clk) begin
        r_data <= raw.pixel_data;
        r_fv   <= raw.frame_valid;
        r_lv   <= raw.line_valid;
        r_fv_d <= r_fv;
    end

    // Frame admission state machine and decimation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_sync;
            r_skip_cnt <= c_skip_zero;
        end else begin
            case (r_state)
                c_st_sync: begin
                    if (!r_fv) begin
                        r_state <= c_st_armed;
                    end
                end
                c_st_armed: begin
                    if (w_fv_rise) begin
                        if (enable && (r_skip_cnt == c_skip_zero)) begin
                            r_state <= c_st_pass;
                        end else begin
                            r_state <= c_st_drop;
                            if (r_skip_cnt != c_skip_zero) begin
                                r_skip_cnt <= r_skip_cnt - c_skip_one;
                            end
                        end
                    end
                end
                c_st_pass: begin
                    if (w_fv_fall) begin
                        r_skip_cnt <= skip;
                        r_state    <= c_st_armed;
                    end
                end
                c_st_drop: begin
                    if (w_fv_fall) begin
                        r_state <= c_st_armed;
                    end
                end
                default: begin
                    r_state <= c_st_sync;
                end
            endcase
        end
    end

    // Gated output register; line strobe outside a frame is never passed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data   <= '0;
            r_out_fv     <= 1'b0;
            r_out_lv     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_data   <= w_fwd ? r_data : '0;
            r_out_fv     <= w_fwd & r_fv;
            r_out_lv     <= w_fwd & r_fv & r_lv;
            r_frame_done <= (r_state == c_st_pass) & w_fv_fall;
        end
    end

    assign gated.pixel_data  = r_out_data;
    assign gated.frame_valid = r_out_fv;
    assign gated.line_valid  = r_out_lv;
    assign frame_done        = r_frame_done;

    frame_geom_checker #(
        .LINE_WORDS  (LINE_WORDS),
        .FRAME_LINES (FRAME_LINES),
        .CNT_W       (CNT_W)
    ) u_geom (
        .clk              (clk),
        .reset            (reset),
        .start            (w_start),
        .frame_valid      (r_out_fv),
        .line_valid       (r_out_lv),
        .err_clear        (err_clear),
        .last_line_words  (last_line_words),
        .last_frame_lines (last_frame_lines),
        .err_line_len     (err_line_len),
        .err_frame_lines  (err_frame_lines)
    );

endmodule
`default_nettype wire

// File: doc/sensor_frame_gate.md
# sensor_frame_gate

Input-conditioning stage between the image-sensor parallel bus and `histogram_module`. It registers the raw two-pixel bus and forwards only whole frames, so the histogram never sees a partial frame after reset or enable. It can decimate frames 1-in-(N+1) and checks each forwarded frame's geometry against the expected line length and line count. Its outputs drive `pixel_data`, `frame_valid` and `line_valid` of `histogram_module` directly.

## Interface
Parameters:
- `LINE_WORDS`, 640: expected 20-bit words (two-pixel beats) per line.
- `FRAME_LINES`, 400: expected lines per frame.
- `CNT_W`, 16: width of the geometry counters and status outputs.

Ports:
- `clk`  in  1  pixel clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  level; permits forwarding starting at the next frame boundary.
- `skip`  in  4  forward one frame, then drop `skip` frames; 0 forwards every frame.
- `err_clear`  in  1  single-cycle pulse; clears the sticky error flags.
- `raw_pixel_data`  in  20  `{pixel_b, pixel_a}` from the sensor.
- `raw_frame_valid`  in  1  raw frame strobe.
- `raw_line_valid`  in  1  raw line strobe.
- `pixel_data`  out  20  to `histogram_module`.
- `frame_valid`  out  1  gated frame strobe.
- `line_valid`  out  1  gated line strobe.
- `frame_done`  out  1  one-cycle pulse at the end of each forwarded frame.
- `last_line_words`  out  CNT_W  word count of the most recent forwarded line.
- `last_frame_lines`  out  CNT_W  line count of the most recent forwarded frame.
- `err_line_len`  out  1  sticky; a forwarded line had word count ≠ `LINE_WORDS`.
- `err_frame_lines`  out  1  sticky; a forwarded frame had line count ≠ `FRAME_LINES`.

## Operation
Stage 1 registers all raw inputs (`r_*`). Edge detection compares `r_*` with its one-cycle-delayed copy.

States:
- SYNC: entered from reset. Go to ARMED when `r_frame_valid`=0.
- ARMED: on a rising edge of `r_frame_valid`:
  - to PASS if `enable`=1 and `skip_cnt`=0;
  - otherwise to DROP, decrementing `skip_cnt` when it is nonzero.
- PASS: forward the frame. On a falling edge of `r_frame_valid`: pulse `frame_done`, latch `last_frame_lines`, reload `skip_cnt` with `skip`, go to ARMED.
- DROP: outputs held inactive. On a falling edge of `r_frame_valid`, go to ARMED.

Gating:
- In PASS, outputs are the stage-1 values passed through an output register.
- In all other states, `pixel_data`=0, `frame_valid`=0, `line_valid`=0.

Geometry counting (PASS only):
- `word_cnt` increments on each cycle with `r_frame_valid & r_line_valid` and saturates at all-ones.
- On a falling edge of `r_line_valid`: latch `last_line_words`, increment `line_cnt` (saturating), set `err_line_len` on mismatch, clear `word_cnt`.
- `line_cnt` is compared with `FRAME_LINES` at the frame falling edge; mismatch sets `err_frame_lines`.
- `line_cnt` and `word_cnt` clear on entry to PASS.
- `raw_line_valid` high while `raw_frame_valid` is low is ignored: it is not forwarded and not counted.

Boundary behaviour:
- `enable` deasserted mid-frame: the current PASS frame completes in full. No truncation, since `histogram_module` treats a `frame_valid` fall as end of frame.
- `skip` is sampled only at reload. Changing it mid-frame has no effect until the end of the current PASS frame.
- `err_clear` in the same cycle as a new error: the error wins and the flag stays set.
- Reset mid-frame: outputs go to 0 on the next clock. The block returns to SYNC and waits for `raw_frame_valid` low, so the frame in progress is never forwarded.
- A line still open at the frame falling edge is counted as a line and length-checked.

## Timing
- Reset values: all outputs 0; `skip_cnt`=0; state SYNC.
- Latency from raw input to gated output is 2 clocks, identical for data, `frame_valid` and `line_valid`, so alignment is preserved.
- `frame_done` asserts in the same cycle as the `frame_valid` falling edge on the outputs.
- `last_line_words`, `last_frame_lines` and the error flags update one clock after the corresponding output falling edge.
- `enable` and `skip` are sampled in ARMED on the cycle the rising edge is detected.

## Structure
- A shared package holds:
  - the state encoding (SYNC, ARMED, PASS, DROP);
  - the default `LINE_WORDS` / `FRAME_LINES` constants, which `histogram_module` instances also use for sizing.
- One natural sub-module: `frame_geom_checker`, containing the word/line counters, the latches and the sticky flags. The FSM and gating stay in the top level.

## Test plan
- Reset asserted with `raw_frame_valid` high mid-frame, then released: no output activity until the next full frame; that frame is forwarded with a 2-clock delay and is bit-identical.
- `skip`=2, six clean frames: frames 1 and 4 forwarded, 2/3/5/6 dropped; `frame_done` pulses exactly twice.
- A 640×400 frame followed by a frame with one 639-word line: `err_line_len`=1, `last_line_words`=639, `err_frame_lines`=0. Then `err_clear` → 0.
- A frame with 399 lines: `last_frame_lines`=399 and `err_frame_lines`=1. `err_clear` coincident with a new mismatch leaves the flag at 1.
- `enable` dropped halfway through a frame: that frame completes to its last word, the next frame is dropped, and re-enabling resumes at the following frame start.
- `raw_line_valid` pulses while `raw_frame_valid`=0: outputs stay 0 and `line_cnt` is unchanged.
